// File: rtl/tlb_sv32_plru.sv
// tlb_sv32_plru: parametrised Sv32 TLB with global pages, tree pseudo-LRU
// replacement, update deduplication and saturating hit/miss counters.
//
// Ports:
//   clk_i, rst_i              clock and asynchronous active-high reset
//   flush_i                   flush request; asid/vaddr of 0 act as wildcards
//   asid_to_be_flushed_i      flush ASID
//   vaddr_to_be_flushed_i     flush virtual address
//   update_*                  entry write from the page-table walker
//   lu_access_i, lu_asid_i,
//   lu_vaddr_i                combinational lookup request
//   lu_hit_o, lu_is_4M_o,
//   lu_content_o              lookup result (zeroed on miss)
//   hit_count_o, miss_count_o saturating lookup counters (registered)
//   full_o                    all entries valid (registered)
module tlb_sv32_plru #(
  parameter int unsigned TLB_ENTRIES = 8,
  parameter int unsigned ASID_WIDTH  = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [31:0]           vaddr_to_be_flushed_i,
  input  logic                  update_valid_i,
  input  logic                  update_is_4M_i,
  input  logic                  update_global_i,
  input  logic [19:0]           update_vpn_i,
  input  logic [ASID_WIDTH-1:0] update_asid_i,
  input  logic [31:0]           update_content_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [31:0]           lu_vaddr_i,
  output logic                  lu_hit_o,
  output logic                  lu_is_4M_o,
  output logic [31:0]           lu_content_o,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o,
  output logic                  full_o
);

  localparam int unsigned IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam int unsigned NODES = TLB_ENTRIES - 1;

  // Tree nodes are heap-ordered: node n has children 2n+1 (left) and 2n+2 (right).
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                  input logic [IDX_W-1:0] idx);
    logic [NODES-1:0] t;
    int unsigned      node;
    logic             b;
    t    = tree;
    node = 32'd0;
    for (int l = 0; l < int'(IDX_W); l++) begin
      b = idx[IDX_W-1-l];
      t[node[IDX_W-1:0]] = ~b;  // point the victim away from the touched side
      node = 32'd2 * node + 32'd1 + 32'(b);
    end
    return t;
  endfunction

  function automatic logic [IDX_W-1:0] plru_victim(input logic [NODES-1:0] tree);
    int unsigned node;
    int unsigned leaf;
    node = 32'd0;
    for (int l = 0; l < int'(IDX_W); l++) begin
      node = 32'd2 * node + 32'd1 + 32'(tree[node[IDX_W-1:0]]);
    end
    leaf = node - NODES;
    return leaf[IDX_W-1:0];
  endfunction

  // A 4 MiB entry only compares the upper ten VPN bits.
  function automatic logic vpn_hit(input logic [19:0] vpn, input logic is_4m,
                                   input logic [31:0] vaddr);
    return (vpn[19:10] == vaddr[31:22]) && (is_4m || (vpn[9:0] == vaddr[21:12]));
  endfunction

  logic [TLB_ENTRIES-1:0] valid_r;
  logic [TLB_ENTRIES-1:0] is_4m_r;
  logic [TLB_ENTRIES-1:0] global_r;
  logic [19:0]            vpn_r     [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0]  asid_r    [TLB_ENTRIES];
  logic [31:0]            content_r [TLB_ENTRIES];
  logic [NODES-1:0]       plru_r;
  logic [31:0]            hit_count_r;
  logic [31:0]            miss_count_r;
  logic                   full_r;

  logic [TLB_ENTRIES-1:0] match_s;
  logic [TLB_ENTRIES-1:0] flush_hit_s;
  logic [TLB_ENTRIES-1:0] valid_next_s;
  logic                   hit_any_s;
  logic                   lu_hit_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic [IDX_W-1:0]       upd_slot_s;
  logic                   upd_en_s;
  logic [NODES-1:0]       plru_next_s;
  logic [31:0]            lu_content_s;
  logic                   lu_is_4m_s;

  assign upd_en_s = update_valid_i & ~flush_i;
  assign lu_hit_s = lu_access_i & hit_any_s;

  // Lookup match vector and lowest-index winner.
  always_comb begin
    match_s   = '0;
    hit_any_s = 1'b0;
    win_idx_s = '0;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      match_s[i] = valid_r[i] && (global_r[i] || (asid_r[i] == lu_asid_i)) &&
                   vpn_hit(vpn_r[i], is_4m_r[i], lu_vaddr_i);
    end
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        hit_any_s = 1'b1;
        win_idx_s = IDX_W'(i);
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

  // Lookup payload mux, zeroed on miss.
  always_comb begin
    lu_content_s = 32'd0;
    lu_is_4m_s   = 1'b0;
    if (lu_hit_s) begin
      lu_content_s = content_r[win_idx_s];
      lu_is_4m_s   = is_4m_r[win_idx_s];
    end else begin
      lu_content_s = 32'd0;
      lu_is_4m_s   = 1'b0;
    end
  end

  // Update slot: duplicate tag first, then lowest invalid, then PLRU victim.
  always_comb begin
    logic             dup_found;
    logic             inv_found;
    logic [IDX_W-1:0] dup_idx;
    logic [IDX_W-1:0] inv_idx;
    dup_found = 1'b0;
    inv_found = 1'b0;
    dup_idx   = '0;
    inv_idx   = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (valid_r[i] && (is_4m_r[i] == update_is_4M_i) && (asid_r[i] == update_asid_i) &&
          (vpn_r[i][19:10] == update_vpn_i[19:10]) &&
          (update_is_4M_i || (vpn_r[i][9:0] == update_vpn_i[9:0]))) begin
        dup_found = 1'b1;
        dup_idx   = IDX_W'(i);
      end else begin
        dup_found = dup_found;
      end
      if (!valid_r[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end else begin
        inv_found = inv_found;
      end
    end
    if (dup_found) begin
      upd_slot_s = dup_idx;
    end else if (inv_found) begin
      upd_slot_s = inv_idx;
    end else begin
      upd_slot_s = plru_victim(plru_r);
    end
  end

  // Flush selection and next valid vector (flush wins over a coincident update).
  always_comb begin
    flush_hit_s  = '0;
    valid_next_s = valid_r;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      if ((asid_to_be_flushed_i == '0) && (vaddr_to_be_flushed_i == 32'd0)) begin
        flush_hit_s[i] = 1'b1;
      end else if (asid_to_be_flushed_i == '0) begin
        flush_hit_s[i] = vpn_hit(vpn_r[i], is_4m_r[i], vaddr_to_be_flushed_i);
      end else if (vaddr_to_be_flushed_i == 32'd0) begin
        flush_hit_s[i] = !global_r[i] && (asid_r[i] == asid_to_be_flushed_i);
      end else begin
        flush_hit_s[i] = !global_r[i] && (asid_r[i] == asid_to_be_flushed_i) &&
                         vpn_hit(vpn_r[i], is_4m_r[i], vaddr_to_be_flushed_i);
      end
    end
    if (flush_i) begin
      valid_next_s = valid_r & ~flush_hit_s;
    end else if (update_valid_i) begin
      valid_next_s[upd_slot_s] = 1'b1;
    end else begin
      valid_next_s = valid_r;
    end
  end

  // PLRU next state: hit touch first so an updated entry ends up MRU.
  always_comb begin
    plru_next_s = plru_r;
    if (lu_hit_s) begin
      plru_next_s = plru_touch(plru_next_s, win_idx_s);
    end else begin
      plru_next_s = plru_next_s;
    end
    if (upd_en_s) begin
      plru_next_s = plru_touch(plru_next_s, upd_slot_s);
    end else begin
      plru_next_s = plru_next_s;
    end
  end

  // Entry array, PLRU tree, counters and full flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r      <= '0;
      is_4m_r      <= '0;
      global_r     <= '0;
      plru_r       <= '0;
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
      full_r       <= 1'b0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        vpn_r[i]     <= 20'd0;
        asid_r[i]    <= '0;
        content_r[i] <= 32'd0;
      end
    end else begin
      valid_r <= valid_next_s;
      plru_r  <= plru_next_s;
      full_r  <= &valid_next_s;
      if (upd_en_s) begin
        is_4m_r[upd_slot_s]   <= update_is_4M_i;
        global_r[upd_slot_s]  <= update_global_i;
        vpn_r[upd_slot_s]     <= update_vpn_i;
        asid_r[upd_slot_s]    <= update_asid_i;
        content_r[upd_slot_s] <= update_content_i;
      end else begin
        is_4m_r <= is_4m_r;
      end
      if (lu_access_i && lu_hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
        hit_count_r <= hit_count_r + 32'd1;
      end else begin
        hit_count_r <= hit_count_r;
      end
      if (lu_access_i && !lu_hit_s && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end else begin
        miss_count_r <= miss_count_r;
      end
    end
  end

  assign lu_hit_o     = lu_hit_s;
  assign lu_is_4M_o   = lu_is_4m_s;
  assign lu_content_o = lu_content_s;
  assign hit_count_o  = hit_count_r;
  assign miss_count_o = miss_count_r;
  assign full_o       = full_r;

endmodule

// File: tb/tb_tlb_sv32_plru.sv
// Directed self-checking bench for tlb_sv32_plru with four entries and 9-bit ASIDs.
module tb_tlb_sv32_plru;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [8:0]  flush_asid;
  logic [31:0] flush_vaddr;
  logic        upd_valid;
  logic        upd_4m;
  logic        upd_global;
  logic [19:0] upd_vpn;
  logic [8:0]  upd_asid;
  logic [31:0] upd_content;
  logic        lu_access;
  logic [8:0]  lu_asid;
  logic [31:0] lu_vaddr;
  logic        lu_hit;
  logic        lu_4m;
  logic [31:0] lu_content;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        full;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_hits   = 0;
  int unsigned exp_misses = 0;

  always #5 clk = ~clk;

  tlb_sv32_plru #(.TLB_ENTRIES(4), .ASID_WIDTH(9)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .asid_to_be_flushed_i (flush_asid),
    .vaddr_to_be_flushed_i(flush_vaddr),
    .update_valid_i       (upd_valid),
    .update_is_4M_i       (upd_4m),
    .update_global_i      (upd_global),
    .update_vpn_i         (upd_vpn),
    .update_asid_i        (upd_asid),
    .update_content_i     (upd_content),
    .lu_access_i          (lu_access),
    .lu_asid_i            (lu_asid),
    .lu_vaddr_i           (lu_vaddr),
    .lu_hit_o             (lu_hit),
    .lu_is_4M_o           (lu_4m),
    .lu_content_o         (lu_content),
    .hit_count_o          (hit_count),
    .miss_count_o         (miss_count),
    .full_o               (full)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic do_update(input logic is4m, input logic glob, input logic [19:0] vpn,
                           input logic [8:0] asid, input logic [31:0] content);
    upd_valid   = 1'b1;
    upd_4m      = is4m;
    upd_global  = glob;
    upd_vpn     = vpn;
    upd_asid    = asid;
    upd_content = content;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [8:0] asid, input logic [31:0] vaddr);
    flush       = 1'b1;
    flush_asid  = asid;
    flush_vaddr = vaddr;
    tick();
    flush = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] va, input logic [8:0] asid,
                        input logic exp_hit, input logic [31:0] exp_content, input logic exp_4m);
    lu_access = 1'b1;
    lu_vaddr  = va;
    lu_asid   = asid;
    #1;
    check_eq({tag, ".hit"}, {31'd0, lu_hit}, {31'd0, exp_hit});
    check_eq({tag, ".content"}, lu_content, exp_content);
    check_eq({tag, ".is4m"}, {31'd0, lu_4m}, {31'd0, exp_4m});
    if (exp_hit) exp_hits++;
    else exp_misses++;
    tick();
    lu_access = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, ".hits"}, hit_count, exp_hits);
    check_eq({tag, ".misses"}, miss_count, exp_misses);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_asid = 9'd0; flush_vaddr = 32'd0;
    upd_valid = 1'b0; upd_4m = 1'b0; upd_global = 1'b0; upd_vpn = 20'd0;
    upd_asid = 9'd0; upd_content = 32'd0;
    lu_access = 1'b0; lu_asid = 9'd0; lu_vaddr = 32'd0;
    #12;
    check_eq("reset.hit", {31'd0, lu_hit}, 32'd0);
    check_eq("reset.full", {31'd0, full}, 32'd0);
    check_counters("reset");
    rst = 1'b0;
    tick();

    // Cold lookup
    lookup("cold", 32'h1234_5000, 9'd1, 1'b0, 32'd0, 1'b0);
    check_counters("cold");

    // Basic update/lookup and deduplication
    do_update(1'b0, 1'b0, 20'h12345, 9'd1, 32'hDEAD_BEEF);
    lookup("basic.same", 32'h1234_5000, 9'd1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    lookup("basic.asid2", 32'h1234_5000, 9'd2, 1'b0, 32'd0, 1'b0);
    do_update(1'b0, 1'b0, 20'h12345, 9'd1, 32'h0BAD_F00D);
    check_eq("dedup.full1", {31'd0, full}, 32'd0);
    lookup("dedup.data", 32'h1234_5000, 9'd1, 1'b1, 32'h0BAD_F00D, 1'b0);

    // Superpage
    do_update(1'b1, 1'b0, 20'h00C00, 9'd1, 32'h1111_0001);
    lookup("super", 32'h00DF_F000, 9'd1, 1'b1, 32'h1111_0001, 1'b1);
    do_update(1'b0, 1'b0, 20'h55555, 9'd2, 32'h5555_0005);
    check_eq("dedup.full3", {31'd0, full}, 32'd0);
    do_update(1'b0, 1'b0, 20'h66666, 9'd2, 32'h6666_0006);
    check_eq("fill.full4", {31'd0, full}, 32'd1);
    check_counters("phase1");

    // PLRU replacement: A,B,C,D; touch A,C; E must evict B
    pulse_reset();
    do_update(1'b0, 1'b0, 20'h0A000, 9'd1, 32'hA000_0000);
    do_update(1'b0, 1'b0, 20'h0B000, 9'd1, 32'hB000_0000);
    do_update(1'b0, 1'b0, 20'h0C000, 9'd1, 32'hC000_0000);
    do_update(1'b0, 1'b0, 20'h0D000, 9'd1, 32'hD000_0000);
    check_eq("plru.full", {31'd0, full}, 32'd1);
    lookup("plru.touchA", 32'h0A00_0000, 9'd1, 1'b1, 32'hA000_0000, 1'b0);
    lookup("plru.touchC", 32'h0C00_0000, 9'd1, 1'b1, 32'hC000_0000, 1'b0);
    do_update(1'b0, 1'b0, 20'h0E000, 9'd1, 32'hE000_0000);
    lookup("plru.B", 32'h0B00_0000, 9'd1, 1'b0, 32'd0, 1'b0);
    lookup("plru.A", 32'h0A00_0000, 9'd1, 1'b1, 32'hA000_0000, 1'b0);
    lookup("plru.C", 32'h0C00_0000, 9'd1, 1'b1, 32'hC000_0000, 1'b0);
    lookup("plru.D", 32'h0D00_0000, 9'd1, 1'b1, 32'hD000_0000, 1'b0);
    lookup("plru.E", 32'h0E00_0000, 9'd1, 1'b1, 32'hE000_0000, 1'b0);
    check_counters("plru");

    // Flush modes
    pulse_reset();
    do_update(1'b0, 1'b1, 20'h11111, 9'd1, 32'hAAAA_0001);
    do_update(1'b0, 1'b0, 20'h22222, 9'd1, 32'hBBBB_0002);
    do_flush(9'd1, 32'd0);
    lookup("fl.asid.N", 32'h2222_2000, 9'd1, 1'b0, 32'd0, 1'b0);
    lookup("fl.asid.G", 32'h1111_1000, 9'd1, 1'b1, 32'hAAAA_0001, 1'b0);
    lookup("fl.asid.Gx", 32'h1111_1000, 9'd7, 1'b1, 32'hAAAA_0001, 1'b0);
    do_flush(9'd0, 32'h1111_1000);
    lookup("fl.va.G", 32'h1111_1000, 9'd1, 1'b0, 32'd0, 1'b0);
    do_update(1'b0, 1'b0, 20'h33333, 9'd3, 32'hCCCC_0003);
    do_update(1'b0, 1'b0, 20'h33333, 9'd4, 32'hDDDD_0004);
    do_update(1'b0, 1'b0, 20'h77777, 9'd5, 32'h7777_0007);
    do_update(1'b0, 1'b0, 20'h88888, 9'd5, 32'h8888_0008);
    check_eq("fl.full4", {31'd0, full}, 32'd1);
    do_flush(9'd3, 32'h3333_3000);
    check_eq("fl.both.full", {31'd0, full}, 32'd0);
    lookup("fl.both.P", 32'h3333_3000, 9'd3, 1'b0, 32'd0, 1'b0);
    lookup("fl.both.Q", 32'h3333_3000, 9'd4, 1'b1, 32'hDDDD_0004, 1'b0);
    do_flush(9'd0, 32'd0);
    lookup("fl.all.Q", 32'h3333_3000, 9'd4, 1'b0, 32'd0, 1'b0);
    lookup("fl.all.R", 32'h7777_7000, 9'd5, 1'b0, 32'd0, 1'b0);
    check_eq("fl.all.full", {31'd0, full}, 32'd0);
    check_counters("flush");

    // Update colliding with a full flush is dropped
    do_update(1'b0, 1'b0, 20'h99999, 9'd1, 32'h9999_0009);
    upd_valid = 1'b1; upd_4m = 1'b0; upd_global = 1'b0;
    upd_vpn = 20'h44444; upd_asid = 9'd1; upd_content = 32'h4444_0004;
    flush = 1'b1; flush_asid = 9'd0; flush_vaddr = 32'd0;
    tick();
    upd_valid = 1'b0;
    flush = 1'b0;
    lookup("coll.upd", 32'h4444_4000, 9'd1, 1'b0, 32'd0, 1'b0);
    lookup("coll.old", 32'h9999_9000, 9'd1, 1'b0, 32'd0, 1'b0);

    // Asynchronous reset mid-cycle after three hits
    do_update(1'b0, 1'b0, 20'h12345, 9'd1, 32'h1234_ABCD);
    for (int k = 0; k < 3; k++) begin
      lookup("rst.pre", 32'h1234_5000, 9'd1, 1'b1, 32'h1234_ABCD, 1'b0);
    end
    check_counters("rst.pre");
    #2;
    lu_access = 1'b1;
    lu_vaddr  = 32'h1234_5000;
    lu_asid   = 9'd1;
    rst = 1'b1;
    #1;
    check_eq("rst.async.hitcnt", hit_count, 32'd0);
    check_eq("rst.async.misscnt", miss_count, 32'd0);
    check_eq("rst.async.hit", {31'd0, lu_hit}, 32'd0);
    check_eq("rst.async.content", lu_content, 32'd0);
    rst = 1'b0;
    lu_access = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    tick();
    lookup("rst.post", 32'h1234_5000, 9'd1, 1'b0, 32'd0, 1'b0);
    check_counters("rst.post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
